fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: stallCtrl  in  1  hazard stall from decode; hold IF/ID contents and PC.
REQ-004 SHALL have port: takeBranch_EXMEM  in  1  redirect request; flush younger work.
REQ-005 SHALL have port: branchTarget_EXMEM  in  16  redirect PC.
REQ-006 SHALL have port: imem_req  out  1  instruction-memory request, level.
REQ-007 SHALL have port: imem_addr  out  16  fetch address; equals PC.
REQ-008 SHALL have port: imem_ready  in  1  data valid on imem_data this cycle.
REQ-009 SHALL have port: imem_data  in  16  instruction word.
REQ-010 SHALL have port: instr_IFID  out  16  IF/ID instruction; consumed by decode.
REQ-011 SHALL have port: PC2_IFID  out  16  IF/ID PC+2 of that instruction.
REQ-012 SHALL have port: valid_IFID  out  1  IF/ID holds a real instruction.
REQ-013 SHALL have port: err  out  1  sticky protocol error.

Function
REQ-014 SHALL implement states FETCH, HOLD, REDIRECT, HALTED; every PC add is 16-bit with wrap (0xFFFE+2=0x0000).
REQ-015 FETCH: imem_req=1, imem_addr=PC; imem_addr SHALL stay stable until imem_ready.
REQ-016 FETCH, ready=1, takeBranch=0, stallCtrl=0: IF/ID <= {imem_data, PC+2, valid=1}; PC <= PC+2; stay FETCH.
REQ-017 FETCH, ready=1, takeBranch=0, stallCtrl=1: IF/ID held; word and PC+2 captured in hold buffer; PC <= PC+2; go HOLD.
REQ-018 FETCH, ready=0, takeBranch=0: stallCtrl=0 -> IF/ID <= bubble; stallCtrl=1 -> IF/ID held.
REQ-019 Bubble SHALL be instr_IFID=16'h0800 (NOP), PC2_IFID unchanged, valid_IFID=0.
REQ-020 FETCH, takeBranch=1, ready=1: data discarded; PC <= branchTarget_EXMEM; IF/ID <= bubble; stay FETCH.
REQ-021 FETCH, takeBranch=1, ready=0: target saved; IF/ID <= bubble; go REDIRECT.
REQ-022 REDIRECT: imem_req=1 at old PC; on ready returned word discarded, PC <= saved target, go FETCH; further takeBranch overwrites saved target.
REQ-023 HOLD: imem_req=0; stallCtrl=0 -> IF/ID <= hold buffer (valid=1), go FETCH; stallCtrl=1 -> remain.
REQ-024 HOLD, takeBranch=1: buffer dropped; PC <= target; IF/ID <= bubble; go FETCH.
REQ-025 takeBranch_EXMEM SHALL take priority over stallCtrl in every state.
REQ-026 Word with bits[15:11]=5'b00000 (HALT) loaded into IF/ID SHALL move state to HALTED (from FETCH or HOLD).
REQ-027 HALTED: imem_req=0; PC and IF/ID held; takeBranch=1 -> PC <= target, IF/ID <= bubble, go FETCH; else stays until reset.
REQ-028 err SHALL set when imem_ready=1 while imem_req=0 and stay set until reset.
REQ-029 Latency: fetched word visible on instr_IFID the cycle after imem_ready; zero-wait memory sustains one instruction per cycle.

Reset
REQ-030 rst=1 at clock edge: PC=0x0000, state=FETCH, instr_IFID=16'h0800, PC2_IFID=0x0000, valid_IFID=0, err=0, hold buffer cleared, saved target cleared.
REQ-031 imem_req SHALL be 0 while rst=1; first request at PC 0x0000 issued the cycle after rst deasserts.
REQ-032 Reset mid-operation (any state, incl. REDIRECT with outstanding request) SHALL abandon all work; a late imem_ready after reset, in FETCH, is accepted as the response for address 0x0000.

Verification
REQ-033 Zero-wait memory, words 0x4001,0x4002,0x4003 at 0,2,4 -> IF/ID shows them on consecutive cycles, PC2_IFID 2,4,6, valid=1.
REQ-034 ready high 1 cycle with stallCtrl=1 for 3 cycles -> IF/ID frozen, state HOLD, imem_req=0; after release word appears with correct PC2, fetch resumes at next address.
REQ-035 ready held low 2 cycles, takeBranch=1 target 0x0100 in first cycle -> late word discarded, next imem_addr=0x0100, only bubbles (0x0800, valid=0) in IF/ID meanwhile.
REQ-036 HALT (0x0000) fetched at 0x0010 -> imem_req drops, PC held; later takeBranch to 0x0020 -> fetch resumes at 0x0020.
REQ-037 imem_ready pulse while imem_req=0 -> err=1 next cycle, stays 1 until rst.
REQ-038 PC=0xFFFE fetch -> PC2_IFID=0x0000, next imem_addr=0x0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives instruction memory from the PC and fills the
// IF/ID pipeline register, handling decode stalls, branch redirects and HALT.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallCtrl,
  input  logic        takeBranch_EXMEM,
  input  logic [15:0] branchTarget_EXMEM,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_IFID,
  output logic [15:0] PC2_IFID,
  output logic        valid_IFID,
  output logic        err
);

  localparam logic [1:0] FETCH    = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc2;
  logic [15:0] saved_target;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == 5'b00000;
  endfunction

  assign pc_plus2  = pc + 16'd2;
  assign imem_req  = !rst && ((state == FETCH) || (state == REDIRECT));
  assign imem_addr = pc;

  // A redirect always wins over a stall; bubbles keep the previous PC2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= 16'h0000;
      instr_IFID   <= NOP_WORD;
      PC2_IFID     <= 16'h0000;
      valid_IFID   <= 1'b0;
      err          <= 1'b0;
      hold_instr   <= 16'h0000;
      hold_pc2     <= 16'h0000;
      saved_target <= 16'h0000;
    end else begin
      if (imem_ready && !imem_req)
        err <= 1'b1;

      case (state)
        FETCH: begin
          if (takeBranch_EXMEM) begin
            instr_IFID <= NOP_WORD;
            valid_IFID <= 1'b0;
            if (imem_ready) begin
              pc <= branchTarget_EXMEM;
            end else begin
              saved_target <= branchTarget_EXMEM;
              state        <= REDIRECT;
            end
          end else if (imem_ready) begin
            pc <= pc_plus2;
            if (stallCtrl) begin
              hold_instr <= imem_data;
              hold_pc2   <= pc_plus2;
              state      <= HOLD;
            end else begin
              instr_IFID <= imem_data;
              PC2_IFID   <= pc_plus2;
              valid_IFID <= 1'b1;
              if (is_halt(imem_data))
                state <= HALTED;
            end
          end else if (!stallCtrl) begin
            instr_IFID <= NOP_WORD;
            valid_IFID <= 1'b0;
          end
        end

        // The request at the old PC is still outstanding; its word is dropped.
        REDIRECT: begin
          if (imem_ready) begin
            pc    <= takeBranch_EXMEM ? branchTarget_EXMEM : saved_target;
            state <= FETCH;
          end else if (takeBranch_EXMEM) begin
            saved_target <= branchTarget_EXMEM;
          end
        end

        HOLD: begin
          if (takeBranch_EXMEM) begin
            pc         <= branchTarget_EXMEM;
            instr_IFID <= NOP_WORD;
            valid_IFID <= 1'b0;
            hold_instr <= 16'h0000;
            hold_pc2   <= 16'h0000;
            state      <= FETCH;
          end else if (!stallCtrl) begin
            instr_IFID <= hold_instr;
            PC2_IFID   <= hold_pc2;
            valid_IFID <= 1'b1;
            state      <= is_halt(hold_instr) ? HALTED : FETCH;
          end
        end

        HALTED: begin
          if (takeBranch_EXMEM) begin
            pc         <= branchTarget_EXMEM;
            instr_IFID <= NOP_WORD;
            valid_IFID <= 1'b0;
            state      <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallCtrl;
  logic        takeBranch_EXMEM;
  logic [15:0] branchTarget_EXMEM;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] instr_IFID;
  logic [15:0] PC2_IFID;
  logic        valid_IFID;
  logic        err;

  int checkCount = 0;
  int errorCount = 0;

  fetch_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stallCtrl          (stallCtrl),
    .takeBranch_EXMEM   (takeBranch_EXMEM),
    .branchTarget_EXMEM (branchTarget_EXMEM),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_data          (imem_data),
    .instr_IFID         (instr_IFID),
    .PC2_IFID           (PC2_IFID),
    .valid_IFID         (valid_IFID),
    .err                (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic branch, input logic [15:0] target,
                               input logic ready, input logic [15:0] data);
    stallCtrl          = stall;
    takeBranch_EXMEM   = branch;
    branchTarget_EXMEM = target;
    imem_ready         = ready;
    imem_data          = data;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfid(input string tag, input logic [15:0] instr, input logic [15:0] pc2, input logic valid);
    checkOutput({tag, "_instr"}, instr_IFID, instr);
    checkOutput({tag, "_pc2"}, PC2_IFID, pc2);
    checkOutput({tag, "_valid"}, {15'd0, valid_IFID}, {15'd0, valid});
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepCycle();
    checkOutput("rst_req", {15'd0, imem_req}, 16'd0);
    checkOutput("rst_err", {15'd0, err}, 16'd0);
    checkIfid("rst", 16'h0800, 16'h0000, 1'b0);

    rst = 1'b0;
    #1;
    checkOutput("first_req", {15'd0, imem_req}, 16'd1);
    checkOutput("first_addr", imem_addr, 16'h0000);

    // Zero-wait stream
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4001);
    stepCycle();
    checkIfid("stream1", 16'h4001, 16'h0002, 1'b1);
    checkOutput("stream1_addr", imem_addr, 16'h0002);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002);
    stepCycle();
    checkIfid("stream2", 16'h4002, 16'h0004, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4003);
    stepCycle();
    checkIfid("stream3", 16'h4003, 16'h0006, 1'b1);
    checkOutput("stream3_addr", imem_addr, 16'h0006);

    // Stall while a word arrives: buffer it, freeze IF/ID for three cycles
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4004);
    stepCycle();
    checkIfid("hold1", 16'h4003, 16'h0006, 1'b1);
    checkOutput("hold1_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checkIfid("holdN", 16'h4003, 16'h0006, 1'b1);
      checkOutput("holdN_req", {15'd0, imem_req}, 16'd0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepCycle();
    checkIfid("release", 16'h4004, 16'h0008, 1'b1);
    checkOutput("release_req", {15'd0, imem_req}, 16'd1);
    checkOutput("release_addr", imem_addr, 16'h0008);

    // Branch while the memory is still busy
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
    stepCycle();
    checkIfid("redir1", 16'h0800, 16'h0008, 1'b0);
    checkOutput("redir1_addr", imem_addr, 16'h0008);
    checkOutput("redir1_req", {15'd0, imem_req}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepCycle();
    checkIfid("redir2", 16'h0800, 16'h0008, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
    stepCycle();
    checkIfid("redir_late", 16'h0800, 16'h0008, 1'b0);
    checkOutput("redir_addr", imem_addr, 16'h0100);

    // HALT fetched at 0x0010
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 16'hDEAD);
    stepCycle();
    checkOutput("br10_addr", imem_addr, 16'h0010);
    checkIfid("br10", 16'h0800, 16'h0008, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    stepCycle();
    checkIfid("halt", 16'h0000, 16'h0012, 1'b1);
    checkOutput("halt_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepCycle();
    stepCycle();
    checkIfid("halted", 16'h0000, 16'h0012, 1'b1);
    checkOutput("halted_addr", imem_addr, 16'h0012);
    checkOutput("halted_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000);
    stepCycle();
    checkOutput("unhalt_addr", imem_addr, 16'h0020);
    checkOutput("unhalt_req", {15'd0, imem_req}, 16'd1);
    checkIfid("unhalt", 16'h0800, 16'h0012, 1'b0);

    // Protocol error: ready while no request is pending
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4010);
    stepCycle();
    checkOutput("pre_err", {15'd0, err}, 16'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555);
    stepCycle();
    checkOutput("err_set", {15'd0, err}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepCycle();
    checkIfid("err_release", 16'h4010, 16'h0022, 1'b1);
    stepCycle();
    checkOutput("err_sticky", {15'd0, err}, 16'd1);

    // Wrap at 0xFFFE
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h1234);
    stepCycle();
    checkOutput("wrap_addr0", imem_addr, 16'hFFFE);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4050);
    stepCycle();
    checkIfid("wrap", 16'h4050, 16'h0000, 1'b1);
    checkOutput("wrap_addr1", imem_addr, 16'h0000);

    // Branch beats stall in HOLD
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4060);
    stepCycle();
    checkOutput("hold2_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000);
    stepCycle();
    checkOutput("holdbr_addr", imem_addr, 16'h0040);
    checkOutput("holdbr_req", {15'd0, imem_req}, 16'd1);
    checkIfid("holdbr", 16'h0800, 16'h0000, 1'b0);

    // Reset during an outstanding redirect
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000);
    stepCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepCycle();
    checkOutput("rst2_req", {15'd0, imem_req}, 16'd0);
    checkOutput("rst2_err", {15'd0, err}, 16'd0);
    checkIfid("rst2", 16'h0800, 16'h0000, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4070);
    checkOutput("rst2_addr", imem_addr, 16'h0000);
    checkOutput("rst2_req1", {15'd0, imem_req}, 16'd1);
    stepCycle();
    checkIfid("late", 16'h4070, 16'h0002, 1'b1);
    checkOutput("late_addr", imem_addr, 16'h0002);
    checkOutput("late_err", {15'd0, err}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
